// File: rtl/nios_led_out.sv
// nios_led_out: Avalon-MM LED/enable output port with set/clear aliases and
// an optional per-bit blink engine.
// Build option: define NIOS_LED_OUT_BLINK_EN to include the blink logic
// (BLINK_MASK, BLINK_DIV, STATUS). Without it, addresses 1-3 read as zero,
// writes to them are dropped, and out_port is simply registered DATA.
module nios_led_out #(
  parameter int              WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int              DIV_WIDTH   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_MASK   = 3'd1;
  localparam logic [2:0] A_DIV    = 3'd2;
  localparam logic [2:0] A_STATUS = 3'd3;
  localparam logic [2:0] A_SET    = 3'd4;
  localparam logic [2:0] A_CLR    = 3'd5;

  logic             wr;
  logic [WIDTH-1:0] data_q;
  logic [31:0]      rd_mux;
  logic [WIDTH-1:0] blank;

  // writedata bits beyond the register widths are deliberately dropped
  logic unused_wd;
  assign unused_wd = ^writedata;

  // zero-wait-state write strobe
  assign wr = chipselect & ~write_n;

  // DATA register, written directly or through the set/clear aliases
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= RESET_VALUE;
    end else if (wr) begin
      case (address)
        A_DATA:  data_q <= writedata[WIDTH-1:0];
        A_SET:   data_q <= data_q | writedata[WIDTH-1:0];
        A_CLR:   data_q <= data_q & ~writedata[WIDTH-1:0];
        default: data_q <= data_q;
      endcase
    end
  end

`ifdef NIOS_LED_OUT_BLINK_EN
  logic [WIDTH-1:0]     mask_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] cnt_q;
  logic                 phase_q;

  // blink engine: any mask/div write restarts the period from phase 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q  <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (wr && (address == A_MASK || address == A_DIV)) begin
      if (address == A_MASK) mask_q <= writedata[WIDTH-1:0];
      else                   div_q  <= writedata[DIV_WIDTH-1:0];
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (mask_q == '0) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (cnt_q == div_q) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + DIV_WIDTH'(1);
    end
  end

  assign blank = mask_q & {WIDTH{phase_q}};

  // read mux for the full register map
  always_comb begin
    rd_mux = '0;
    case (address)
      A_DATA:   rd_mux = 32'(data_q);
      A_MASK:   rd_mux = 32'(mask_q);
      A_DIV:    rd_mux = 32'(div_q);
      A_STATUS: rd_mux = 32'(phase_q);
      default:  rd_mux = '0;
    endcase
  end
`else
  assign blank = '0;

  // read mux: only DATA is backed by storage in this build
  always_comb begin
    rd_mux = '0;
    if (address == A_DATA) rd_mux = 32'(data_q);
  end
`endif

  // registered read data, loaded every cycle regardless of chipselect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_mux;
  end

  // registered output: DATA with blinking bits blanked during phase 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) out_port <= RESET_VALUE;
    else       out_port <= data_q & ~blank;
  end

endmodule

// File: doc/nios_led_out.md
NIOS_LED_OUT -- requirements
Module: nios_led_out

Interface
REQ-001 The block SHALL take parameter WIDTH, default 4: number of output bits driven on out_port.
REQ-002 The block SHALL take parameter RESET_VALUE, default 0: DATA register value after reset.
REQ-003 The block SHALL take parameter DIV_WIDTH, default 16: width of the blink divider register.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all logic SHALL be rising-edge clk.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port address, input, 3 bits: Avalon-MM word address.
REQ-007 The block SHALL have port chipselect, input, 1 bit: Avalon-MM slave select.
REQ-008 The block SHALL have port write_n, input, 1 bit: active-low write strobe.
REQ-009 The block SHALL have port writedata, input, 32 bits: write data.
REQ-010 The block SHALL have port readdata, output, 32 bits: registered read data.
REQ-011 The block SHALL have port out_port, output, WIDTH bits: drives rover LEDs and enables.

Function
REQ-012 A write SHALL occur on any clk edge with chipselect=1 and write_n=0; there are no wait states.
REQ-013 The register map SHALL be: 0 DATA (RW); 1 BLINK_MASK (RW); 2 BLINK_DIV (RW, DIV_WIDTH bits); 3 STATUS (RO, bit0 = phase); 4 OUTSET (WO); 5 OUTCLEAR (WO); 6-7 reserved.
REQ-014 A write to OUTSET SHALL perform DATA <= DATA | writedata[WIDTH-1:0].
REQ-015 A write to OUTCLEAR SHALL perform DATA <= DATA & ~writedata[WIDTH-1:0].
REQ-016 Writes to reserved addresses and to STATUS SHALL be ignored.
REQ-017 Every clk edge, readdata SHALL load the zero-extended value at address, independent of chipselect, giving a read latency of 1 cycle.
REQ-018 Reads of OUTSET, OUTCLEAR and reserved addresses SHALL return 0.
REQ-019 A read of a register during the cycle it is written SHALL return the pre-write value.
REQ-020 Writedata bits above WIDTH (above DIV_WIDTH for BLINK_DIV) SHALL be ignored and SHALL read back as 0.
REQ-021 Blink counter behaviour:
  - If BLINK_MASK = 0, the counter SHALL be held at 0 and phase at 0.
  - Otherwise the counter SHALL increment each cycle.
  - When the counter equals BLINK_DIV, the counter SHALL return to 0 and phase SHALL toggle, so the half-period is BLINK_DIV+1 cycles.
  - BLINK_DIV = 0 SHALL toggle phase every cycle.
REQ-022 A write to BLINK_DIV or BLINK_MASK SHALL clear the counter and phase to 0 on the same edge.
REQ-023 out_port SHALL equal DATA & ~(BLINK_MASK & {WIDTH{phase}}) and SHALL be registered, so it changes 1 cycle after the write edge or phase change.

Reset
REQ-024 While reset is asserted, the block SHALL hold:
  - DATA = RESET_VALUE
  - BLINK_MASK = 0, BLINK_DIV = 0
  - counter = 0, phase = 0
  - readdata = 0
  - out_port = RESET_VALUE[WIDTH-1:0]
REQ-025 Reset asserted mid-blink SHALL abort the blink immediately, without waiting for clk; after release, blinking SHALL stay off until BLINK_MASK is rewritten.

Configuration
REQ-026 Macro NIOS_LED_OUT_BLINK_EN defined: the blink logic of REQ-021 to REQ-023 SHALL be present.
REQ-027 Macro NIOS_LED_OUT_BLINK_EN undefined:
  - No counter or phase logic SHALL be present.
  - Addresses 1-3 SHALL read 0 and ignore writes.
  - out_port SHALL equal registered DATA.
  - All other behaviour SHALL be unchanged.

Verification
REQ-028 Reset: assert reset with RESET_VALUE=4'hA -> out_port=4'hA and readdata=0; read DATA after release -> 0x0000000A.
REQ-029 Write/set/clear: write DATA=0x5, then OUTSET=0x2, then OUTCLEAR=0x4 -> out_port sequence 0x5, 0x7, 0x3, each 1 cycle after its write; a DATA read in the write cycle returns the old value.
REQ-030 Blink: with DATA=0xF, write BLINK_DIV=3 then BLINK_MASK=0x1 -> out_port alternates 0xF / 0xE every 4 cycles; STATUS bit0 tracks phase.
REQ-031 Divider rewrite mid-period: rewrite BLINK_DIV=1 during phase=1 -> phase returns to 0 next edge and the half-period becomes 2 cycles.
REQ-032 Boundaries:
  - Writes to addresses 6 and 7 with 0xFFFFFFFF -> no register change; reads return 0.
  - Write DATA=0xFFFFFFF0 -> DATA reads 0x00000000.
REQ-033 Build without NIOS_LED_OUT_BLINK_EN: repeat REQ-030 stimulus -> out_port constant 0xF and reads of addresses 1-3 return 0.
